ex_mem_wb_pipe: RTL and testbench

//  Back-end pipeline register chain (ID->EX->MEM->WB) for the 19-bit CPU. Carries destination

---
 rtl/ex_mem_wb_pipe.sv | 124 ++++++++++++
 tb/tb_ex_mem_wb_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM/WB pipeline register chain with load-use hazard detection for the 19-bit CPU.
// Drives MEM/WB destination, write-enable and data to the forwarding unit.
module ex_mem_wb_pipe #(
  parameter int DATA_W = 19,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_load_data,
  output logic              stall,
  output logic [REG_AW-1:0] MEM_rd,
  output logic              MEM_regwrite,
  output logic [DATA_W-1:0] MEM_data,
  output logic [REG_AW-1:0] WB_rd,
  output logic              WB_regwrite,
  output logic [DATA_W-1:0] WB_data,
  output logic [CNT_W-1:0]  stall_count
);

  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_regwrite;
  logic              r_ex_memread;

  logic              r_mem_valid;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_regwrite;
  logic              r_mem_memread;
  logic [DATA_W-1:0] r_mem_data;

  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_regwrite;
  logic [DATA_W-1:0] r_wb_data;

  logic [CNT_W-1:0]  r_stall_count;

  logic              w_stall;
  logic              w_bubble;
  logic              w_cnt_sat;

  // A taken branch squashes the ID instruction, so it also cancels the hazard it would cause.
  always_comb begin
    w_stall = id_valid & r_ex_valid & r_ex_memread & r_ex_regwrite &
              ((r_ex_rd == id_rs) | (r_ex_rd == id_rt)) & ~flush;
    w_bubble  = flush | w_stall;
    w_cnt_sat = (r_stall_count == {CNT_W{1'b1}});
  end

  // EX stage: bubble on flush or hazard, otherwise accept the ID instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= {REG_AW{1'b0}};
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
    end else if (w_bubble) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= {REG_AW{1'b0}};
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
    end else begin
      r_ex_valid    <= id_valid;
      r_ex_rd       <= id_rd;
      r_ex_regwrite <= id_regwrite & id_valid;
      r_ex_memread  <= id_memread & id_valid;
    end
  end

  // MEM and WB advance every cycle; a stall only holds the front end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= {REG_AW{1'b0}};
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_data     <= {DATA_W{1'b0}};
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= {REG_AW{1'b0}};
      r_wb_regwrite  <= 1'b0;
      r_wb_data      <= {DATA_W{1'b0}};
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memread  <= r_ex_memread;
      r_mem_data     <= ex_result;
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_data      <= r_mem_memread ? mem_load_data : r_mem_data;
    end
  end

  // Saturating count of hazard stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= {CNT_W{1'b0}};
    end else if (w_stall && !w_cnt_sat) begin
      r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign stall        = w_stall;
  assign MEM_rd       = r_mem_rd;
  assign MEM_regwrite = r_mem_valid & r_mem_regwrite;
  assign MEM_data     = r_mem_data;
  assign WB_rd        = r_wb_rd;
  assign WB_regwrite  = r_wb_valid & r_wb_regwrite;
  assign WB_data      = r_wb_data;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Bench for ex_mem_wb_pipe: directed scenarios then random traffic against an in-bench
// instruction-slot model; a second instance with CNT_W=4 exercises counter saturation.
module tb_ex_mem_wb_pipe;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        id_regwrite, id_memread, flush;
  logic [18:0] ex_result, mem_load_data;

  logic        stall, MEM_regwrite, WB_regwrite;
  logic [2:0]  MEM_rd, WB_rd;
  logic [18:0] MEM_data, WB_data;
  logic [15:0] stall_count;

  logic        s4_stall, s4_MEM_regwrite, s4_WB_regwrite;
  logic [2:0]  s4_MEM_rd, s4_WB_rd;
  logic [18:0] s4_MEM_data, s4_WB_data;
  logic [3:0]  s4_stall_count;

  int total = 0;
  int bad   = 0;

  ex_mem_wb_pipe dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .ex_result(ex_result), .mem_load_data(mem_load_data),
    .stall(stall), .MEM_rd(MEM_rd), .MEM_regwrite(MEM_regwrite), .MEM_data(MEM_data),
    .WB_rd(WB_rd), .WB_regwrite(WB_regwrite), .WB_data(WB_data), .stall_count(stall_count)
  );

  ex_mem_wb_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .ex_result(ex_result), .mem_load_data(mem_load_data),
    .stall(s4_stall), .MEM_rd(s4_MEM_rd), .MEM_regwrite(s4_MEM_regwrite), .MEM_data(s4_MEM_data),
    .WB_rd(s4_WB_rd), .WB_regwrite(s4_WB_regwrite), .WB_data(s4_WB_data),
    .stall_count(s4_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One in-flight instruction as the model sees it.
  typedef struct {
    bit        v;
    bit [2:0]  rd;
    bit        rw;
    bit        ld;
    bit [18:0] d;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  int    m_stalls;

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 1'b0; s.rd = 3'd0; s.rw = 1'b0; s.ld = 1'b0; s.d = 19'd0;
    return s;
  endfunction

  function automatic void model_reset();
    m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot();
    m_stalls = 0;
  endfunction

  // A load in EX that writes a register ID reads must wait one cycle, unless ID is squashed.
  function automatic bit model_hazard();
    if (!id_valid || flush || !m_ex.v || !m_ex.ld || !m_ex.rw) return 1'b0;
    return (m_ex.rd == id_rs) || (m_ex.rd == id_rt);
  endfunction

  function automatic void model_clock(input bit hz);
    slot_t nx;
    m_wb   = m_mem;
    m_wb.d = m_mem.ld ? mem_load_data : m_mem.d;
    m_mem   = m_ex;
    m_mem.d = ex_result;
    if (flush || hz) begin
      nx = empty_slot();
    end else begin
      nx.v = id_valid; nx.rd = id_rd; nx.rw = id_regwrite && id_valid;
      nx.ld = id_memread && id_valid; nx.d = 19'd0;
    end
    m_ex = nx;
    if (hz) m_stalls++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit hz;
    int sat16, sat4;
    hz    = model_hazard();
    sat16 = (m_stalls > 65535) ? 65535 : m_stalls;
    sat4  = (m_stalls > 15) ? 15 : m_stalls;
    chk("stall", {31'd0, stall}, {31'd0, hz});
    chk("mem_rd", {29'd0, MEM_rd}, {29'd0, m_mem.rd});
    chk("mem_rw", {31'd0, MEM_regwrite}, {31'd0, m_mem.v && m_mem.rw});
    chk("mem_data", {13'd0, MEM_data}, {13'd0, m_mem.d});
    chk("wb_rd", {29'd0, WB_rd}, {29'd0, m_wb.rd});
    chk("wb_rw", {31'd0, WB_regwrite}, {31'd0, m_wb.v && m_wb.rw});
    chk("wb_data", {13'd0, WB_data}, {13'd0, m_wb.d});
    chk("stall_count", {16'd0, stall_count}, sat16);
    chk("c4_stall", {31'd0, s4_stall}, {31'd0, hz});
    chk("c4_wb_data", {13'd0, s4_WB_data}, {13'd0, m_wb.d});
    chk("c4_mem_rw", {30'd0, s4_MEM_regwrite, s4_WB_regwrite},
        {30'd0, m_mem.v && m_mem.rw, m_wb.v && m_wb.rw});
    chk("c4_rd", {26'd0, s4_MEM_rd, s4_WB_rd}, {26'd0, m_mem.rd, m_wb.rd});
    chk("c4_mem_data", {13'd0, s4_MEM_data}, {13'd0, m_mem.d});
    chk("c4_stall_count", {28'd0, s4_stall_count}, sat4);
  endtask

  // Drive one ID-stage cycle at the falling edge, check before the rising edge, then advance the model.
  task automatic step(input bit v, input bit [2:0] rs, input bit [2:0] rt, input bit [2:0] rd,
                      input bit rw, input bit ld, input bit fl,
                      input bit [18:0] exr, input bit [18:0] mld);
    bit hz;
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_regwrite = rw; id_memread = ld; flush = fl;
    ex_result = exr; mem_load_data = mld;
    #1;
    check_all();
    hz = model_hazard();
    @(posedge clk);
    model_clock(hz);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int saved;

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs = 3'd0; id_rt = 3'd0; id_rd = 3'd0;
    id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
    ex_result = 19'd0; mem_load_data = 19'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_rw", {30'd0, MEM_regwrite, WB_regwrite}, 32'd0);
    chk("reset_data", {13'd0, MEM_data | WB_data}, 32'd0);
    chk("reset_count", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    idle(2);

    // ALU op rd=3 with its result arriving while it sits in EX.
    step(1'b1, 3'd5, 3'd6, 3'd3, 1'b1, 1'b0, 1'b0, 19'h00000, 19'h7FFFF);
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 19'h1ABCD, 19'h7FFFF);
    #1;
    chk("alu_mem_rd", {29'd0, MEM_rd}, 32'd3);
    chk("alu_mem_rw", {31'd0, MEM_regwrite}, 32'd1);
    chk("alu_mem_data", {13'd0, MEM_data}, 32'h1ABCD);
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 19'h00000, 19'h7FFFF);
    #1;
    chk("alu_wb_rd", {29'd0, WB_rd}, 32'd3);
    chk("alu_wb_rw", {31'd0, WB_regwrite}, 32'd1);
    chk("alu_wb_data", {13'd0, WB_data}, 32'h1ABCD);
    idle(2);

    // Load rd=2 followed by a reader of r2: one stall, then the load data reaches WB.
    saved = stall_count;
    step(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 19'h00000, 19'h00000);
    #1;
    chk("lu_stall_hi", {31'd0, stall}, 32'd0);
    id_valid = 1'b1; id_rs = 3'd2; #1;
    chk("lu_stall_on", {31'd0, stall}, 32'd1);
    step(1'b1, 3'd2, 3'd4, 3'd5, 1'b1, 1'b0, 1'b0, 19'h01234, 19'h00000);
    chk("lu_count", {16'd0, stall_count}, saved + 1);
    step(1'b1, 3'd2, 3'd4, 3'd5, 1'b1, 1'b0, 1'b0, 19'h00000, 19'h00055);
    chk("lu_bubble_mem", {31'd0, MEM_regwrite}, 32'd0);
    chk("lu_load_wb", {13'd0, WB_data}, 32'h00055);
    idle(3);

    // Same hazard with a branch flush: flush wins.
    saved = stall_count;
    step(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 19'h00000, 19'h00000);
    step(1'b1, 3'd2, 3'd2, 3'd6, 1'b1, 1'b0, 1'b1, 19'h00011, 19'h00000);
    chk("fl_count", {16'd0, stall_count}, saved);
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 19'h00000, 19'h00099);
    chk("fl_bubble", {31'd0, MEM_regwrite}, 32'd0);
    idle(2);

    // Reset with three valid instructions in flight.
    step(1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 19'h00101, 19'h00000);
    step(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 19'h00202, 19'h00000);
    step(1'b1, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0, 19'h00303, 19'h00000);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mem_rw", {31'd0, MEM_regwrite}, 32'd0);
    chk("rst_wb_rw", {31'd0, WB_regwrite}, 32'd0);
    chk("rst_count", {16'd0, stall_count}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // Back-to-back dependent loads: a stall every other cycle, 19+ stalls total.
    for (int i = 0; i < 40; i++)
      step(1'b1, 3'd1, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 19'(i), 19'(i * 3));
    #1;
    chk("sat4_count", {28'd0, s4_stall_count}, 32'd15);
    chk("sat16_count", {16'd0, stall_count}, 32'd20);
    idle(3);

    // Random traffic.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 3'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
           19'($urandom), 19'($urandom));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
